// File: rtl/riscv_writeback.sv
// Register-file writeback arbiter: ALU results win, load results queue in a small FIFO,
// and a pending-load scoreboard reports busy operands. Optional macro: RISCV_WB_BYPASS_EN.
package riscv_wb_pkg;
  typedef enum logic {
    RF_WRITE_DISABLE = 1'b0,
    RF_WRITE         = 1'b1
  } rf_wen_t;
endpackage

module riscv_writeback
  import riscv_wb_pkg::*;
#(
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_LENGTH = 5,
  parameter int NUM_REGS    = 32,
  parameter int LQ_DEPTH    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  input  logic [ADDR_LENGTH-1:0] alu_rd,
  input  logic [WORD_LENGTH-1:0] alu_data,
  input  logic                   lsu_valid,
  input  logic [ADDR_LENGTH-1:0] lsu_rd,
  input  logic [WORD_LENGTH-1:0] lsu_data,
  output logic                   lsu_ready,
  input  logic                   issue_valid,
  input  logic [ADDR_LENGTH-1:0] issue_rd,
  input  logic [ADDR_LENGTH-1:0] rs1_addr,
  input  logic [ADDR_LENGTH-1:0] rs2_addr,
  output logic                   rs1_busy,
  output logic                   rs2_busy,
  output rf_wen_t                rf_write_en,
  output logic [ADDR_LENGTH-1:0] rf_write_addr,
  output logic [WORD_LENGTH-1:0] rf_data
);

  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = $clog2(LQ_DEPTH + 1);

  typedef struct packed {
    logic [ADDR_LENGTH-1:0] rd;
    logic [WORD_LENGTH-1:0] data;
  } lq_entry_t;

  lq_entry_t              lq_mem [LQ_DEPTH];
  lq_entry_t              head;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [NUM_REGS-1:0]    pending;
  logic [NUM_REGS-1:0]    pending_next;

  logic                   push;
  logic                   pop;
  logic                   sel_valid;
  logic [ADDR_LENGTH-1:0] sel_rd;
  logic [WORD_LENGTH-1:0] sel_data;

  assign head      = lq_mem[rd_ptr];
  assign lsu_ready = (count != CNT_W'(LQ_DEPTH));
  assign push      = lsu_valid && lsu_ready;

  // ALU always wins; the queue head drains only in ALU-free cycles.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pop       = 1'b0;
    sel_valid = alu_valid;
    sel_rd    = alu_rd;
    sel_data  = alu_data;
    if (!alu_valid && count != '0) begin
      pop       = 1'b1;
      sel_valid = 1'b1;
      sel_rd    = head.rd;
      sel_data  = head.data;
    end
  end

  // Set is applied after clear so a same-cycle re-issue of the popped rd stays pending.
  always_comb begin
    pending_next = pending;
    if (pop) pending_next[head.rd] = 1'b0;
    if (issue_valid && issue_rd != '0) pending_next[issue_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_comb begin
    rs1_busy = pending[rs1_addr];
    rs2_busy = pending[rs2_addr];
`ifdef RISCV_WB_BYPASS_EN
    // The selected write reaches the register file next cycle, so the operand is already safe.
    if (sel_valid && sel_rd == rs1_addr && rs1_addr != '0) rs1_busy = 1'b0;
    if (sel_valid && sel_rd == rs2_addr && rs2_addr != '0) rs2_busy = 1'b0;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      pending       <= '0;
      rf_write_en   <= RF_WRITE_DISABLE;
      rf_write_addr <= '0;
      rf_data       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      pending     <= pending_next;
      rf_write_en <= (sel_valid && sel_rd != '0) ? RF_WRITE : RF_WRITE_DISABLE;
      if (sel_valid) begin
        rf_write_addr <= sel_rd;
        rf_data       <= sel_data;
      end
    end
  end

  // NOTE: queue storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !rst) lq_mem[wr_ptr] <= '{rd: lsu_rd, data: lsu_data};
  end

endmodule

// File: tb/tb_riscv_writeback.sv
// Self-checking bench for riscv_writeback: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_riscv_writeback;
  import riscv_wb_pkg::*;

  localparam int LQ = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_busy;
  logic        rs2_busy;
  rf_wen_t     rf_write_en;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_data;

  int checks = 0;
  int errors = 0;

  riscv_writeback #(
    .WORD_LENGTH(32), .ADDR_LENGTH(5), .NUM_REGS(32), .LQ_DEPTH(LQ)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_data(rf_data)
  );

  always #5 clk = ~clk;

`ifdef RISCV_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Reference model state: the load queue, pending set and last expected write.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;
  ent_t        lq[$];
  bit [31:0]   pend;
  bit          m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    issue_valid = 0; issue_rd = 0;
  endtask

  task automatic model_step();
    bit          sel;
    logic [4:0]  srd;
    logic [31:0] sdat;
    bit          popped;
    logic [4:0]  prd;
    bit          ready;
    ent_t        e;
    if (rst) begin
      lq.delete();
      pend = '0; m_en = 0; m_addr = '0; m_data = '0;
      return;
    end
    ready = lq.size() < LQ;
    sel = 0; popped = 0; srd = '0; sdat = '0; prd = '0;
    if (alu_valid) begin
      sel = 1; srd = alu_rd; sdat = alu_data;
    end else if (lq.size() != 0) begin
      e = lq.pop_front();
      sel = 1; srd = e.rd; sdat = e.data; popped = 1; prd = e.rd;
    end
    if (lsu_valid && ready) lq.push_back('{rd: lsu_rd, data: lsu_data});
    if (popped) pend[prd] = 0;
    if (issue_valid && issue_rd != 0) pend[issue_rd] = 1;
    pend[0] = 0;
    m_en = sel && (srd != 0);
    if (sel) begin
      m_addr = srd; m_data = sdat;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rs1_addr = 5'd4; rs2_addr = 5'd17;
    rst = 1; tick(); tick();
    rst = 0;
    checks++;
    if (rf_write_en !== RF_WRITE_DISABLE) begin errors++; $display("FAIL reset_en: got %0d want 0", rf_write_en); end
    checks++;
    if (rf_write_addr !== 5'd0 || rf_data !== 32'd0) begin errors++; $display("FAIL reset_addr_data: got %0d/%h want 0/0", rf_write_addr, rf_data); end
    checks++;
    if (lsu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", lsu_ready); end
    checks++;
    if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b%b want 00", rs1_busy, rs2_busy); end
  endtask

  task automatic test_alu_write();
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 0;
    checks++;
    if (rf_write_en !== RF_WRITE || rf_write_addr !== 5'd5 || rf_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL alu_write: got en=%0d addr=%0d data=%h want 1/5/deadbeef", rf_write_en, rf_write_addr, rf_data);
    end
    tick();
    checks++;
    if (rf_write_en !== RF_WRITE_DISABLE || rf_write_addr !== 5'd5 || rf_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL alu_idle_hold: got en=%0d addr=%0d data=%h want 0/5/deadbeef", rf_write_en, rf_write_addr, rf_data);
    end
  endtask

  task automatic test_load_busy();
    rs1_addr = 5'd7;
    issue_valid = 1; issue_rd = 5'd7;
    tick();
    issue_valid = 0;
    #1;
    checks++;
    if (rs1_busy !== 1'b1) begin errors++; $display("FAIL busy_after_issue: got %b want 1", rs1_busy); end
    tick();
    lsu_valid = 1; lsu_rd = 5'd7; lsu_data = 32'h11;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h100 + i;
      #1;
      checks++;
      if (rs1_busy !== 1'b1) begin errors++; $display("FAIL busy_during_alu%0d: got %b want 1", i, rs1_busy); end
      tick();
      lsu_valid = 0;
      checks++;
      if (rf_write_en !== RF_WRITE || rf_write_addr !== 5'd1 || rf_data !== 32'h100 + i) begin
        errors++; $display("FAIL alu_priority%0d: got en=%0d addr=%0d data=%h", i, rf_write_en, rf_write_addr, rf_data);
      end
    end
    alu_valid = 0;
    #1;
    checks++;
    if (rs1_busy !== !BYPASS) begin errors++; $display("FAIL busy_pop_cycle: got %b want %b", rs1_busy, !BYPASS); end
    tick();
    checks++;
    if (rf_write_en !== RF_WRITE || rf_write_addr !== 5'd7 || rf_data !== 32'h11) begin
      errors++; $display("FAIL load_write: got en=%0d addr=%0d data=%h want 1/7/11", rf_write_en, rf_write_addr, rf_data);
    end
    checks++;
    if (rs1_busy !== 1'b0) begin errors++; $display("FAIL busy_cleared: got %b want 0", rs1_busy); end
  endtask

  task automatic test_back_to_back();
    alu_valid = 1; alu_rd = 5'd2; alu_data = 32'h2;
    lsu_valid = 1; lsu_rd = 5'd10; lsu_data = 32'hA0;
    tick();
    checks++;
    if (lsu_ready !== 1'b1) begin errors++; $display("FAIL ready_one_entry: got %b want 1", lsu_ready); end
    lsu_rd = 5'd11; lsu_data = 32'hB0;
    tick();
    checks++;
    if (lsu_ready !== 1'b0) begin errors++; $display("FAIL ready_full: got %b want 0", lsu_ready); end
    lsu_rd = 5'd12; lsu_data = 32'hC0;
    tick();
    checks++;
    if (lsu_ready !== 1'b0) begin errors++; $display("FAIL ready_still_full: got %b want 0", lsu_ready); end
    lsu_valid = 0; alu_valid = 0;
    tick();
    checks++;
    if (rf_write_en !== RF_WRITE || rf_write_addr !== 5'd10 || rf_data !== 32'hA0) begin
      errors++; $display("FAIL fifo_first: got en=%0d addr=%0d data=%h want 1/10/a0", rf_write_en, rf_write_addr, rf_data);
    end
    checks++;
    if (lsu_ready !== 1'b1) begin errors++; $display("FAIL ready_after_pop: got %b want 1", lsu_ready); end
    tick();
    checks++;
    if (rf_write_en !== RF_WRITE || rf_write_addr !== 5'd11 || rf_data !== 32'hB0) begin
      errors++; $display("FAIL fifo_second: got en=%0d addr=%0d data=%h want 1/11/b0", rf_write_en, rf_write_addr, rf_data);
    end
    tick();
    checks++;
    if (rf_write_en !== RF_WRITE_DISABLE) begin errors++; $display("FAIL fifo_drained: got en=%0d want 0", rf_write_en); end
  endtask

  task automatic test_rd_zero();
    rs1_addr = 5'd0;
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h55;
    issue_valid = 1; issue_rd = 5'd0;
    tick();
    alu_valid = 0; issue_valid = 0;
    checks++;
    if (rf_write_en !== RF_WRITE_DISABLE) begin errors++; $display("FAIL alu_rd0: got en=%0d want 0", rf_write_en); end
    checks++;
    if (rs1_busy !== 1'b0) begin errors++; $display("FAIL busy_rd0: got %b want 0", rs1_busy); end
    lsu_valid = 1; lsu_rd = 5'd0; lsu_data = 32'h66;
    tick();
    lsu_valid = 0;
    tick();
    checks++;
    if (rf_write_en !== RF_WRITE_DISABLE) begin errors++; $display("FAIL load_rd0: got en=%0d want 0", rf_write_en); end
    tick();
    checks++;
    if (rf_write_en !== RF_WRITE_DISABLE || lsu_ready !== 1'b1) begin
      errors++; $display("FAIL load_rd0_consumed: got en=%0d ready=%b want 0/1", rf_write_en, lsu_ready);
    end
  endtask

  task automatic test_set_wins_and_reset();
    rs1_addr = 5'd3;
    issue_valid = 1; issue_rd = 5'd3;
    tick();
    issue_valid = 0;
    alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h1;
    lsu_valid = 1; lsu_rd = 5'd3; lsu_data = 32'h33;
    tick();
    lsu_valid = 0; alu_valid = 0;
    issue_valid = 1; issue_rd = 5'd3;
    tick();
    issue_valid = 0;
    checks++;
    if (rf_write_en !== RF_WRITE || rf_write_addr !== 5'd3 || rf_data !== 32'h33) begin
      errors++; $display("FAIL set_wins_write: got en=%0d addr=%0d data=%h", rf_write_en, rf_write_addr, rf_data);
    end
    checks++;
    if (rs1_busy !== 1'b1) begin errors++; $display("FAIL set_wins_busy: got %b want 1", rs1_busy); end
    // Fill the queue behind ALU traffic, then reset with valids still asserted.
    rs2_addr = 5'd20;
    alu_valid = 1; alu_rd = 5'd2; alu_data = 32'h2;
    lsu_valid = 1; lsu_rd = 5'd20; lsu_data = 32'h20;
    issue_valid = 1; issue_rd = 5'd20;
    tick();
    lsu_rd = 5'd21; lsu_data = 32'h21; issue_rd = 5'd21;
    tick();
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (rf_write_en !== RF_WRITE_DISABLE || lsu_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid: got en=%0d ready=%b want 0/1", rf_write_en, lsu_ready);
    end
    idle_inputs();
    tick();
    checks++;
    if (rf_write_en !== RF_WRITE_DISABLE || rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
      errors++; $display("FAIL reset_discard: got en=%0d busy=%b%b want 0/00", rf_write_en, rs1_busy, rs2_busy);
    end
    tick();
    checks++;
    if (rf_write_en !== RF_WRITE_DISABLE) begin errors++; $display("FAIL reset_no_late_write: got en=%0d want 0", rf_write_en); end
  endtask

  task automatic test_bypass();
    rs2_addr = 5'd9;
    issue_valid = 1; issue_rd = 5'd9;
    tick();
    issue_valid = 0;
    alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h1;
    lsu_valid = 1; lsu_rd = 5'd9; lsu_data = 32'h99;
    tick();
    alu_valid = 0; lsu_valid = 0;
    #1;
    checks++;
    if (rs2_busy !== !BYPASS) begin errors++; $display("FAIL bypass_pop: got %b want %b", rs2_busy, !BYPASS); end
    tick();
    checks++;
    if (rf_write_en !== RF_WRITE || rf_write_addr !== 5'd9 || rs2_busy !== 1'b0) begin
      errors++; $display("FAIL bypass_write: got en=%0d addr=%0d busy=%b", rf_write_en, rf_write_addr, rs2_busy);
    end
  endtask

  task automatic test_random();
    bit          exp_b1;
    bit          exp_b2;
    bit          sel;
    logic [4:0]  srd;
    idle_inputs();
    rst = 1;
    model_step();
    tick();
    rst = 0;
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      alu_valid   = ($urandom_range(0, 9) < 4);
      alu_rd      = 5'($urandom_range(0, 7));
      alu_data    = $urandom;
      lsu_valid   = ($urandom_range(0, 1) == 1);
      lsu_rd      = 5'($urandom_range(0, 7));
      lsu_data    = $urandom;
      issue_valid = ($urandom_range(0, 9) < 3);
      issue_rd    = 5'($urandom_range(0, 7));
      rs1_addr    = 5'($urandom_range(0, 7));
      rs2_addr    = 5'($urandom_range(0, 7));
      #1;
      sel = alu_valid || lq.size() != 0;
      srd = alu_valid ? alu_rd : (lq.size() != 0 ? lq[0].rd : 5'd0);
      exp_b1 = pend[rs1_addr] && !(BYPASS && sel && srd == rs1_addr && rs1_addr != 0);
      exp_b2 = pend[rs2_addr] && !(BYPASS && sel && srd == rs2_addr && rs2_addr != 0);
      checks++;
      if (rs1_busy !== exp_b1 || rs2_busy !== exp_b2) begin
        errors++; $display("FAIL rand_busy@%0d: got %b%b want %b%b", i, rs1_busy, rs2_busy, exp_b1, exp_b2);
      end
      checks++;
      if (lsu_ready !== (lq.size() < LQ)) begin
        errors++; $display("FAIL rand_ready@%0d: got %b want %b", i, lsu_ready, lq.size() < LQ);
      end
      model_step();
      tick();
      checks++;
      if (rf_write_en !== (m_en ? RF_WRITE : RF_WRITE_DISABLE) ||
          (m_en && (rf_write_addr !== m_addr || rf_data !== m_data))) begin
        errors++; $display("FAIL rand_write@%0d: got en=%0d addr=%0d data=%h want en=%0d addr=%0d data=%h",
                           i, rf_write_en, rf_write_addr, rf_data, m_en, m_addr, m_data);
      end
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    rs1_addr = 0; rs2_addr = 0;
    test_reset();
    test_alu_write();
    test_load_busy();
    test_back_to_back();
    test_rd_zero();
    test_set_wins_and_reset();
    test_bypass();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
